serial_alu_ctrl: RTL and testbench
==================================

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 Parameter: WIDTH, default 64, operand/result width in bits; legal range is 2 or more.
REQ-002 Port: clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: start  in  1  request to begin one operation.
REQ-005 Port: op  in  2  operation: 0 ADD (a+b), 1 SUB (a-b), 2 AND, 3 XOR.
REQ-006 Port: a  in  WIDTH  first operand.
REQ-007 Port: b  in  WIDTH  second operand.
REQ-008 Port: busy  out  1  high while an operation is in progress.
REQ-009 Port: done  out  1  one-cycle pulse when result and flags are valid.
REQ-010 Port: result  out  WIDTH  operation result.
REQ-011 Port: cout  out  1  final carry out of the MSB; 0 for AND and XOR.
REQ-012 Port: zf, sf, of  out  1 each  zero, sign and overflow condition codes.

Function
REQ-013 The block SHALL compute one bit per cycle, LSB first, through a single 1-bit full-adder datapath.
REQ-014 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 SHALL latch a, b and op, clear the bit counter, set busy, and move to RUN.
REQ-016 When start is accepted for SUB, the carry SHALL be set to 1; otherwise it SHALL be set to 0.
REQ-017 In RUN, each cycle SHALL process bit i as follows:
- ADD: a[i], b[i], carry.
- SUB: a[i], ~b[i], carry.
- AND/XOR: bitwise result; carry held at 0.
REQ-018 In RUN, result bit i SHALL be written, the carry register updated, and i incremented.
REQ-019 After bit WIDTH-1 is processed, RUN SHALL move to DONE.
REQ-020 In DONE, the block SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-021 Latency: start accepted at edge k gives done=1 during the cycle following edge k+WIDTH+1, which is WIDTH+2 edges total.
REQ-022 start SHALL be ignored in RUN and DONE; there is no queuing, and changes to a, b or op after acceptance have no effect.
REQ-023 result, cout and the flags SHALL hold their values from done until the next accepted start.
REQ-024 When the next start is accepted, result SHALL be cleared to 0.
REQ-025 start asserted in IDLE on the same cycle that DONE returns to IDLE SHALL be accepted one cycle after done.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap past WIDTH-1.

Reset
REQ-027 When rst=1, the block SHALL go to IDLE and drive busy=0, done=0, result=0, cout=0, zf=0, sf=0, of=0.
REQ-028 When rst=1, the carry and the bit counter SHALL clear to 0.
REQ-029 rst SHALL take priority over start.
REQ-030 rst asserted during RUN or DONE SHALL abort the operation with no done pulse.

Configuration
REQ-031 The macro SERIAL_ALU_FLAGS_EN SHALL control whether the condition codes are compiled in.
REQ-032 With SERIAL_ALU_FLAGS_EN defined, zf, sf and of SHALL update on the DONE transition as follows:
- zf = (result==0).
- sf = result[WIDTH-1].
- of for ADD = sign(a)==sign(b) and sign(result)!=sign(a).
- of for SUB = sign(a)!=sign(b) and sign(result)!=sign(a).
- of = 0 for AND and XOR.
REQ-033 Without SERIAL_ALU_FLAGS_EN, the zf, sf and of ports SHALL remain present and tied to 0, with no flag logic synthesized.

Structure
REQ-034 Package serial_alu_pkg SHALL hold the op encoding constants (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_XOR=3) and the state typedef (IDLE, RUN, DONE).
REQ-035 The existing 1-bit full-adder cell add_1 SHALL be instantiated once as the only sub-module, port order (cout, sum, a, b, cin).

Verification (WIDTH=64, SERIAL_ALU_FLAGS_EN defined)
REQ-036 ADD 0x7FFF_FFFF_FFFF_FFFF + 1 SHALL give result 0x8000_0000_0000_0000, cout=0, of=1, sf=1, zf=0, with done exactly 66 edges after start.
REQ-037 SUB 5 - 5 SHALL give result 0, cout=1, zf=1, sf=0, of=0.
REQ-038 ADD 0xFFFF_FFFF_FFFF_FFFF + 1 SHALL give result 0, cout=1, zf=1, of=0.
REQ-039 XOR 0xF0F0 ^ 0xFFFF SHALL give result 0x0F0F, cout=0, of=0, sf=0; a following AND 0xF0F0 & 0x0FF0 SHALL give 0x00F0.
REQ-040 A second start pulsed at cycle 10 of a RUN SHALL be ignored: exactly one done, and the first operation's result unchanged.
REQ-041 rst asserted at cycle 30 of RUN SHALL abort with no done; busy=0 and result=0 on the next cycle, and a new start then completes normally.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared op encodings and FSM state type for the bit-serial ALU controller.
package serial_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Only ADD and SUB propagate a carry between bit slices.
  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/add_1.sv
// 1-bit full-adder cell used as the serial ALU's only datapath element.
module add_1 (
  output logic cout,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: one result bit per clk, LSB first, through a single full adder.
// Condition codes zf/sf/of are built only when SERIAL_ALU_FLAGS_EN is defined; otherwise tied to 0.
//
// state | meaning
// IDLE  | waiting for start; result/cout/flags hold last values
// RUN   | processing bit cnt through the full adder
// DONE  | all bits processed; pulse done next cycle and return to IDLE
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_b;
  logic             fa_sum;
  logic             fa_cout;
  logic             bit_res;

  // SUB is a + ~b + 1, the +1 coming from the carry preset at start.
  always_comb begin
    fa_b    = (op_q == OP_SUB) ? ~b_q[cnt] : b_q[cnt];
    bit_res = (op_q == OP_AND) ? (a_q[cnt] & b_q[cnt]) : fa_sum;
  end

  add_1 u_add_1 (
    .cout (fa_cout),
    .sum  (fa_sum),
    .a    (a_q[cnt]),
    .b    (fa_b),
    .cin  (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q   <= op;
            a_q    <= a;
            b_q    <= b;
            carry  <= (op == OP_SUB);
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          result[cnt] <= bit_res;
          carry       <= is_arith(op_q) ? fa_cout : 1'b0;
          if (cnt == LAST) state <= DONE;
          else             cnt   <= cnt + CW'(1);
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          cout  <= carry;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zf <= 1'b0;
      sf <= 1'b0;
      of <= 1'b0;
    end else if (state == DONE) begin
      zf <= (result == '0);
      sf <= result[WIDTH-1];
      case (op_q)
        OP_ADD:  of <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result[WIDTH-1] != a_q[WIDTH-1]);
        OP_SUB:  of <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (result[WIDTH-1] != a_q[WIDTH-1]);
        default: of <= 1'b0;
      endcase
    end
  end
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed plus random checks of serial_alu_ctrl (WIDTH=64) against an arithmetic reference model.
module tb_serial_alu_ctrl;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, zf, sf, of;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .zf(zf), .sf(sf), .of(of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, signed range test for overflow.
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic c, output logic z,
                       output logic s, output logic v);
    logic [W:0] t;
    logic signed [W:0] ts;
    t = '0; ts = '0; v = 1'b0; c = 1'b0;
    case (o)
      2'd0: begin
        t  = {1'b0, x} + {1'b0, y};
        r  = t[W-1:0];
        c  = t[W];
        ts = $signed({x[W-1], x}) + $signed({y[W-1], y});
        v  = (ts[W] != ts[W-1]);
      end
      2'd1: begin
        r  = x - y;
        c  = (x >= y);
        ts = $signed({x[W-1], x}) - $signed({y[W-1], y});
        v  = (ts[W] != ts[W-1]);
      end
      2'd2: r = x & y;
      default: r = x ^ y;
    endcase
    z = (r == '0);
    s = r[W-1];
`ifndef SERIAL_ALU_FLAGS_EN
    z = 1'b0; s = 1'b0; v = 1'b0;
`endif
  endtask

  // ign_cyc: pulse start again that many edges into RUN; b2b: return inside the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int ign_cyc, input bit b2b);
    logic [W-1:0] er;
    logic ec, ez, es, ev;
    int edges;
    bit seen;
    model(o, x, y, er, ec, ez, es, ev);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    chk("busy_after_start", W'(busy), W'(1));
    edges = 0; seen = 1'b0;
    while (!seen && edges < 200) begin
      start = (ign_cyc != 0 && edges == ign_cyc);
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", W'(seen), W'(1));
    chk("latency_edges", W'(edges + 1), W'(W + 2));
    chk("result", result, er);
    chk("cout", W'(cout), W'(ec));
    chk("zf", W'(zf), W'(ez));
    chk("sf", W'(sf), W'(es));
    chk("of", W'(of), W'(ev));
    chk("busy_at_done", W'(busy), W'(0));
    if (!b2b) begin
      @(posedge clk); #1;
      chk("done_one_cycle", W'(done), W'(0));
      chk("result_hold", result, er);
      chk("no_requeue", W'(busy), W'(0));
    end
  endtask

  initial begin
    int dones;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_result", result, '0);
    chk("rst_flags", W'({cout, zf, sf, of}), W'(0));
    // rst must win over a simultaneous start
    start = 1'b1;
    @(posedge clk); #1;
    chk("rst_over_start", W'(busy), W'(0));
    start = 1'b0;
    rst = 1'b0;

    run_op(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    run_op(2'd1, 64'd5, 64'd5, 0, 1'b0);
    run_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    run_op(2'd3, 64'hF0F0, 64'hFFFF, 0, 1'b1);
    run_op(2'd2, 64'hF0F0, 64'h0FF0, 0, 1'b0);
    run_op(2'd1, 64'h8000_0000_0000_0000, 64'd1, 0, 1'b0);
    run_op(2'd1, 64'd3, 64'd7, 10, 1'b0);

    // abort by reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 64'h1234; b = 64'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_result", result, '0);
    chk("abort_done", W'(done), W'(0));
    dones = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_no_done", W'(dones), W'(0));
    run_op(2'd0, 64'd100, 64'd23, 0, 1'b0);

    for (int i = 0; i < 12; i++)
      run_op(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'($urandom));

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
